dec_instr_arbiter: RTL

DEC_INSTR_ARBITER -- requirements
Module: dec_instr_arbiter

---
 rtl/dec_test_pkg.sv | 20 ++
 rtl/dec_instr_fifo.sv | 66 ++++++
 rtl/dec_instr_arbiter.sv | 136 +++++++++++++
 3 files changed

// File: rtl/dec_test_pkg.sv
// Shared types for the instruction arbiter: FSM states, buffer entry
// layout and the instruction word width.
package dec_test_pkg;

    localparam int INSTR_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // One buffered instruction together with the requester it came from.
    typedef struct packed {
        logic               src;
        logic [INSTR_W-1:0] instr;
    } fifo_entry_t;

endpackage

// File: rtl/dec_instr_fifo.sv
// Small synchronous FIFO of {src, instr} entries. Push is gated on the
// registered full flag only, so a pop in the same cycle never makes room
// for a push while full. Pointers wrap naturally (DEPTH is a power of two)
// and the occupancy is tracked in a separate counter.
module dec_instr_fifo
    import dec_test_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      push,
    input  fifo_entry_t               wdata,
    input  logic                      pop,
    output fifo_entry_t               rdata,
    output logic                      full,
    output logic                      empty,
    output logic [$clog2(DEPTH):0]    count
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH) + 1;

    fifo_entry_t       mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [CW-1:0]     count_q;
    logic              do_push;
    logic              do_pop;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    // Storage array; contents need no reset since the count guards reads.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/dec_instr_arbiter.sv
// Two-requester round-robin instruction arbiter feeding a decoder through a
// small FIFO. A run accepts NUM_TRANS words, then drains the buffer and
// parks in DONE until the next start pulse.
module dec_instr_arbiter
    import dec_test_pkg::*;
#(
    parameter int NUM_TRANS  = 10,
    parameter int FIFO_DEPTH = 4
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               start_i,
    input  logic               req0_valid_i,
    input  logic [INSTR_W-1:0] req0_instr_i,
    output logic               req0_ready_o,
    input  logic               req1_valid_i,
    input  logic [INSTR_W-1:0] req1_instr_i,
    output logic               req1_ready_o,
    output logic               instr_valid_o,
    output logic [INSTR_W-1:0] instr_rdata_o,
    output logic               instr_src_o,
    input  logic               instr_ready_i,
    output logic [15:0]        trans_cnt_o,
    output logic               done_o
);

    localparam int          CW       = $clog2(FIFO_DEPTH) + 1;
    localparam logic [15:0] LAST_CNT = 16'(NUM_TRANS);

    state_t          state;
    state_t          next_state;
    logic [15:0]     trans_cnt_q;
    logic            rr_q;        // 0: req0 has priority, 1: req1 has priority
    logic            done_q;

    logic            accept_ok;
    logic            accept;
    logic            winner;
    logic            clear_cnt;
    logic            pop;
    fifo_entry_t     push_entry;
    fifo_entry_t     head;
    logic            fifo_full;
    logic            fifo_empty;
    logic [CW-1:0]   fifo_count;

    // Acceptance window: only while running, with room and budget left.
    assign accept_ok = (state == ST_RUN) && !fifo_full &&
                       (trans_cnt_q < LAST_CNT) && !rst_i;

    // Round-robin pick; when only one requester is valid it wins outright.
    always_comb begin
        winner = 1'b0;
        if (req0_valid_i && req1_valid_i) begin
            winner = rr_q;
        end else if (req1_valid_i) begin
            winner = 1'b1;
        end
    end

    assign accept       = accept_ok && (req0_valid_i || req1_valid_i);
    assign req0_ready_o = accept && !winner;
    assign req1_ready_o = accept && winner;

    assign push_entry.src   = winner;
    assign push_entry.instr = winner ? req1_instr_i : req0_instr_i;

    // Decoder side sees the FIFO head directly; nothing bypasses the buffer.
    assign instr_valid_o = !fifo_empty && !rst_i;
    assign instr_rdata_o = instr_valid_o ? head.instr : '0;
    assign instr_src_o   = instr_valid_o ? head.src   : 1'b0;
    assign pop           = instr_valid_o && instr_ready_i;

    assign trans_cnt_o = trans_cnt_q;
    assign done_o      = done_q;

    // A start pulse is honoured only from IDLE or DONE.
    assign clear_cnt = start_i && ((state == ST_IDLE) || (state == ST_DONE));

    dec_instr_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk_i),
        .rst   (rst_i),
        .push  (accept),
        .wdata (push_entry),
        .pop   (pop),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // Run sequencing: leave RUN on the edge of the last acceptance, leave
    // DRAIN once the buffer has emptied.
    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: begin
                if (start_i) next_state = ST_RUN;
            end
            ST_RUN: begin
                if (accept && (trans_cnt_q == LAST_CNT - 16'd1)) next_state = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (fifo_count == '0) next_state = ST_DONE;
            end
            ST_DONE: begin
                if (start_i) next_state = ST_RUN;
            end
            default: next_state = ST_IDLE;
        endcase
    end

    // State, run counter, round-robin pointer and registered done flag.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state       <= ST_IDLE;
            trans_cnt_q <= '0;
            rr_q        <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state  <= next_state;
            done_q <= (next_state == ST_DONE);
            if (clear_cnt) begin
                trans_cnt_q <= '0;
            end else if (accept && (trans_cnt_q < LAST_CNT)) begin
                trans_cnt_q <= trans_cnt_q + 16'd1;
            end
            if (accept) begin
                rr_q <= ~winner;
            end
        end
    end

endmodule
